demux1x2_buf: RTL and testbench

Buffered 1-to-2 demultiplexer: accepts one word per cycle from a single valid/ready source and steers it to output A or B according to a per-word select bit. Each output owns a 2-entry FIFO, so the two sinks stall independently and no ready path is combinational from a sink back to the source. It is the steering counterpart of the `mux2x1` selector. In the core it sits where one response stream (for example, a shared memory read port) fans out to two consumers (fetch and load/store).

---
 rtl/demux1x2_buf.sv | 112 +++++++++++
 tb/tb_demux1x2_buf.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/demux1x2_buf.sv
// Buffered 1-to-2 demultiplexer: per-word select steers a valid/ready stream into one of two 2-entry FIFOs.
// Optional per-output delivered-word counters (a_cnt/b_cnt) are built when DEMUX_CNT_EN is defined.
module demux1x2_buf_fifo #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [n-1:0] wdata,
    input  logic         ready,
    output logic         full,
    output logic         valid,
    output logic [n-1:0] data
);
    logic [1:0][n-1:0] mem;
    logic              wp;
    logic              rp;
    logic [1:0]        occ;
    logic              pop;

    // full comes from registered occupancy only, keeping ready paths sink-independent
    assign full  = (occ == 2'd2);
    assign valid = (occ != 2'd0);
    assign pop   = valid & ready;
    assign data  = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module demux1x2_buf #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [n-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]  a_cnt,
    output logic [15:0]  b_cnt
`endif
);
    logic [1:0]        push;
    logic [1:0]        full;
    logic [1:0]        valid;
    logic [1:0]        ready;
    logic [1:0][n-1:0] data;
    logic              accept;

    assign in_ready = ~full[in_sel];
    assign accept   = in_valid & in_ready;
    assign push     = {accept & in_sel, accept & ~in_sel};
    assign ready    = {b_ready, a_ready};

    // index 0 is output A, index 1 is output B
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        demux1x2_buf_fifo #(.n(n)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .wdata (in_data),
            .ready (ready[g]),
            .full  (full[g]),
            .valid (valid[g]),
            .data  (data[g])
        );
    end

    assign a_valid = valid[0];
    assign b_valid = valid[1];
    assign a_data  = data[0];
    assign b_data  = data[1];

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt <= 16'd0;
            b_cnt <= 16'd0;
        end else begin
            if (a_valid & a_ready) a_cnt <= a_cnt + 16'd1;
            if (b_valid & b_ready) b_cnt <= b_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux1x2_buf.sv
// Directed bench for demux1x2_buf: vector table for steering/stall/full-pop plus wrap, reset and counter sequences.
module tb_demux1x2_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready = 1'b0;
    logic        b_ready = 1'b0;
`ifdef DEMUX_CNT_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demux1x2_buf dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DEMUX_CNT_EN
        , .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        s;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        e_ir;
        logic        e_av;
        logic [31:0] e_ad;
        logic        e_bv;
        logic [31:0] e_bd;
    } vec_t;

    vec_t vt[15];

    initial begin
        // steering, both sinks ready
        vt[0]  = '{1, 0, 32'hA0, 1, 1, 1, 0, 0,      0, 0};
        vt[1]  = '{1, 1, 32'hB0, 1, 1, 1, 1, 32'hA0, 0, 0};
        vt[2]  = '{1, 0, 32'hA1, 1, 1, 1, 0, 0,      1, 32'hB0};
        vt[3]  = '{0, 0, 32'h0,  1, 1, 1, 1, 32'hA1, 0, 0};
        vt[4]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0,      0, 0};
        // B stalled: two accepted, third refused, A keeps flowing
        vt[5]  = '{1, 1, 32'hB1, 1, 0, 1, 0, 0,      0, 0};
        vt[6]  = '{1, 1, 32'hB2, 1, 0, 1, 0, 0,      1, 32'hB1};
        vt[7]  = '{1, 1, 32'hB3, 1, 0, 0, 0, 0,      1, 32'hB1};
        vt[8]  = '{1, 0, 32'hA2, 1, 0, 1, 0, 0,      1, 32'hB1};
        vt[9]  = '{1, 0, 32'hA3, 1, 0, 1, 1, 32'hA2, 1, 32'hB1};
        // B full with a same-cycle pop: still refused, accepted next cycle
        vt[10] = '{1, 1, 32'hB3, 1, 1, 0, 1, 32'hA3, 1, 32'hB1};
        vt[11] = '{1, 1, 32'hB3, 1, 0, 1, 0, 0,      1, 32'hB2};
        vt[12] = '{0, 0, 32'h0,  1, 1, 1, 0, 0,      1, 32'hB2};
        vt[13] = '{0, 0, 32'h0,  1, 1, 1, 0, 0,      1, 32'hB3};
        vt[14] = '{0, 0, 32'h0,  1, 1, 1, 0, 0,      0, 0};

        // reset state
        #3;
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
        chk("rst_a_cnt", {16'd0, a_cnt}, 32'd0);
        chk("rst_b_cnt", {16'd0, b_cnt}, 32'd0);
`endif
        @(negedge clk) rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].v, vt[i].s, vt[i].d, vt[i].ar, vt[i].br);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_ir});
            chk($sformatf("v%0d_a_valid", i), {31'd0, a_valid}, {31'd0, vt[i].e_av});
            chk($sformatf("v%0d_b_valid", i), {31'd0, b_valid}, {31'd0, vt[i].e_bv});
            if (vt[i].e_av) chk($sformatf("v%0d_a_data", i), a_data, vt[i].e_ad);
            if (vt[i].e_bv) chk($sformatf("v%0d_b_data", i), b_data, vt[i].e_bd);
            step();
        end

        // wrap-around: 10 words at full rate, no bubble after the first
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, 0, 32'hC0 + i, 1, 1);
            @(negedge clk);
            chk($sformatf("wrap%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("wrap%0d_a_valid", i), {31'd0, a_valid}, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk($sformatf("wrap%0d_a_data", i), a_data, 32'hC0 + i - 1);
            step();
        end
        drive(0, 0, 0, 1, 1);
        step();

        // fill both FIFOs, then reset mid-stream
        drive(1, 0, 32'hD0, 0, 0); step();
        drive(1, 1, 32'hD1, 0, 0); step();
        drive(1, 0, 32'hD2, 0, 0); step();
        drive(1, 1, 32'hD3, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        chk("fill_a_valid", {31'd0, a_valid}, 32'd1);
        chk("fill_b_valid", {31'd0, b_valid}, 32'd1);
        chk("fill_a_head", a_data, 32'hD0);
        chk("fill_b_head", b_data, 32'hD1);
        chk("fill_in_ready_a", {31'd0, in_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("midrst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("midrst_in_ready_a", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        chk("midrst_in_ready_b", {31'd0, in_ready}, 32'd1);
        @(negedge clk) rst = 1'b0;
        step();
        drive(1, 0, 32'h1, 1, 1);
        @(negedge clk);
        chk("postrst_a_valid0", {31'd0, a_valid}, 32'd0);
        step();
        drive(0, 0, 0, 1, 1);
        @(negedge clk);
        chk("postrst_a_valid1", {31'd0, a_valid}, 32'd1);
        chk("postrst_a_data", a_data, 32'h1);
        chk("postrst_b_valid", {31'd0, b_valid}, 32'd0);
        step();

`ifdef DEMUX_CNT_EN
        // counter wrap: 65534 pops, then three more
        rst = 1'b1;
        #1 rst = 1'b0;
        drive(1, 0, 32'hE0, 1, 0);
        for (int c = 0; c < 65535; c++) step();
        @(negedge clk);
        chk("cnt_a_fffe", {16'd0, a_cnt}, 32'h0000FFFE);
        step(); @(negedge clk);
        chk("cnt_a_ffff", {16'd0, a_cnt}, 32'h0000FFFF);
        step(); @(negedge clk);
        chk("cnt_a_0000", {16'd0, a_cnt}, 32'h00000000);
        step(); @(negedge clk);
        chk("cnt_a_0001", {16'd0, a_cnt}, 32'h00000001);
        chk("cnt_b_hold", {16'd0, b_cnt}, 32'h00000000);
        drive(0, 0, 0, 0, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
